zx_spi_feeder: RTL and testbench
================================

Name: zx_spi_feeder

Overview:
- SPI initiator that loads the ZX expander CPLD's four SPI-addressed shadow registers: config, mouse, kempston and keyboard.
- Drives SPI_SCK, SPI_NSS, SPI_MOSI and SPI_A so the CPLD's per-address shift registers end up holding exactly the supplied words.
- Sits on the host/control side; requests come from firmware or a scan engine.
- One frame per request, fixed-priority arbitration, glitch-free address switching.

Parameters:
- HALF_DIV, 4, SCK half-period in CLK14M cycles (≥1).
- GAP, 2, CLK14M cycles with NSS high and SPI_A stable before each frame (≥1).

Ports:
- CLK14M  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- CFG_REQ  in  1  one-cycle request: send config frame.
- MOUSE_REQ  in  1  one-cycle request: send mouse frame.
- KMP_REQ  in  1  one-cycle request: send kempston frame.
- KBD_REQ  in  1  one-cycle request: send keyboard frame.
- CFG_DATA  in  8  config word.
- MOUSE_DATA  in  24  [23:16]=Y, [15:8]=X, [7:0]=buttons.
- KMP_DATA  in  8  joystick word.
- KBD_DATA  in  40  key matrix word as it must appear in the CPLD register.
- SPI_SCK  out  1  serial clock, idle low.
- SPI_NSS  out  1  frame select, active low.
- SPI_MOSI  out  1  serial data.
- SPI_A  out  2  register address: 00 cfg, 01 mouse, 10 kempston, 11 kbd.
- BUSY  out  1  high from frame select until NSS deassert.
- DONE  out  1  one-cycle pulse when NSS returns high.
- DONE_CH  out  2  channel of the completed frame; valid with DONE.

Behaviour:
- Reset values: SCK=0, NSS=1, MOSI=0, A=00, BUSY=0, DONE=0, DONE_CH=00. All pending flags and the shift register are cleared.
- Reset asserted mid-frame aborts immediately. The resulting partial register contents in the CPLD are accepted.
- Each REQ sets a pending flag. Repeated REQs while pending collapse into one frame.
- Arbitration in IDLE, priority cfg > kbd > mouse > kempston.
- On frame select:
  - The winning pending flag clears.
  - The data word is snapshotted from its input in that cycle; later input changes do not affect the frame.
  - A REQ for the same channel in the same cycle leaves the flag set.
- Frame length: 8 (cfg, kempston), 24 (mouse), 40 (kbd) bits.
- Bit order is MSB first; the receiver shift-lefts, so bit N-1 is sent first.
- Keyboard bits are sent inverted, because the receiver stores ~MOSI. The CPLD kbd register then equals KBD_DATA.
- States:
  - IDLE: no pending flag. SCK=0, NSS=1.
  - SETUP: SPI_A updated, NSS=1, SCK=0, held GAP cycles. BUSY=1 from entry.
  - SELECT: NSS=0, MOSI=first bit, SCK=0, held HALF_DIV cycles.
  - HIGH: SCK=1, held HALF_DIV cycles.
  - LOW: SCK=0, MOSI=next bit, held HALF_DIV cycles. After the last HIGH, go to TAIL instead.
  - TAIL: SCK=0, MOSI=0, NSS=0, held HALF_DIV cycles.
  - RELEASE: NSS=1 for one cycle, DONE=1, DONE_CH=channel. BUSY falls next cycle; return to IDLE.
- SPI_A changes only in SETUP entry, with NSS=1 and SCK=0, so the receiver's gated clocks never glitch.
- MOSI changes only while SCK=0.
- Exactly N rising SCK edges occur per frame.
- Bit counter is 6 bits wide and does not wrap: the last bit index is N-1.
- Back-to-back frames always pass through RELEASE and SETUP.
- Frame duration = GAP + HALF_DIV·(2N+2) + 1 cycles. Example: cfg at defaults = 2 + 4·18 + 1 = 75.
- Outputs are registered, with no combinational path from inputs to SPI pins.

Test Plan:
- Reset, then CFG_REQ with CFG_DATA=0xA5 -> A=00; MOSI at each SCK rise = 1,0,1,0,0,1,0,1; exactly 8 rises; DONE with DONE_CH=00 at cycle 75 after request; model register=0xA5.
- KBD_REQ with KBD_DATA=0x00_0000_0001 -> A=11; MOSI=1 on rises 1–39 and 0 on rise 40; receiver model (stores ~MOSI) = 0x0000000001.
- MOUSE_REQ and KMP_REQ in the same cycle, data 0x123456 / 0x1F -> mouse frame (A=01, 24 rises) then kempston frame (A=10, 8 rises); A changes only while NSS=1; two DONE pulses, DONE_CH=01 then 10.
- CFG_REQ during an active kbd frame -> kbd frame completes unchanged, then cfg frame; changing KBD_DATA mid-frame does not alter transmitted bits.
- Three KMP_REQ pulses while busy -> exactly one extra kempston frame.
- RESET asserted after 10 SCK rises of a kbd frame -> same-cycle NSS=1, SCK=0, BUSY=0, no DONE; pending flags empty afterwards.

Source files
------------

// File: rtl/zx_spi_feeder.sv
// zx_spi_feeder: SPI initiator that loads the ZX expander CPLD's four
// SPI-addressed shadow registers (config, mouse, kempston, keyboard).
//
// Ports:
//   CLK14M      system clock, all logic on posedge
//   RESET       asynchronous active-high reset
//   *_REQ       one-cycle frame requests (cfg, mouse, kempston, kbd)
//   *_DATA      words to load; sampled when the frame is selected
//   SPI_SCK     serial clock, idle low
//   SPI_NSS     frame select, active low
//   SPI_MOSI    serial data, MSB first
//   SPI_A       register address: 00 cfg, 01 mouse, 10 kempston, 11 kbd
//   BUSY        high from frame select until NSS deasserts
//   DONE        one-cycle pulse when NSS returns high
//   DONE_CH     channel of the completed frame, valid with DONE
module zx_spi_feeder #(
  parameter int unsigned HALF_DIV = 4,
  parameter int unsigned GAP      = 2
) (
  input  logic        CLK14M,
  input  logic        RESET,
  input  logic        CFG_REQ,
  input  logic        MOUSE_REQ,
  input  logic        KMP_REQ,
  input  logic        KBD_REQ,
  input  logic [7:0]  CFG_DATA,
  input  logic [23:0] MOUSE_DATA,
  input  logic [7:0]  KMP_DATA,
  input  logic [39:0] KBD_DATA,
  output logic        SPI_SCK,
  output logic        SPI_NSS,
  output logic        SPI_MOSI,
  output logic [1:0]  SPI_A,
  output logic        BUSY,
  output logic        DONE,
  output logic [1:0]  DONE_CH
);

  localparam int unsigned MaxHold = (HALF_DIV > GAP) ? HALF_DIV : GAP;
  localparam int unsigned CntW    = (MaxHold > 1) ? $clog2(MaxHold) : 1;
  localparam logic [CntW-1:0] HalfLd = CntW'(HALF_DIV - 1);
  localparam logic [CntW-1:0] GapLd  = CntW'(GAP - 1);

  typedef enum logic [2:0] {
    StIdle, StSetup, StSelect, StHigh, StLow, StTail, StRelease
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      bit_q, bit_d;    // SCK rises issued so far in this frame
  logic [5:0]      len_q, len_d;
  logic [1:0]      ch_q, ch_d;
  logic [39:0]     shreg_q, shreg_d;
  logic [3:0]      pend_q, pend_d;
  logic [3:0]      req_vec;
  logic [1:0]      sel;
  logic            hold_done;

  logic            sck_d, nss_d, mosi_d, busy_d, done_d;
  logic [1:0]      a_d, done_ch_d;

  // Indexed by channel code, which is also the SPI_A value.
  assign req_vec   = {KBD_REQ, KMP_REQ, MOUSE_REQ, CFG_REQ};
  assign hold_done = (cnt_q == '0);

  // Fixed priority: cfg > kbd > mouse > kempston.
  always_comb begin
    sel = 2'd2;
    if (pend_q[0])      sel = 2'd0;
    else if (pend_q[3]) sel = 2'd3;
    else if (pend_q[1]) sel = 2'd1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    len_d   = len_q;
    ch_d    = ch_q;
    shreg_d = shreg_q;
    pend_d  = pend_q | req_vec;

    case (state_q)
      StIdle: begin
        if (|pend_q) begin
          state_d     = StSetup;
          cnt_d       = GapLd;
          bit_d       = '0;
          ch_d        = sel;
          // A same-cycle request for the winner keeps its flag set.
          pend_d[sel] = req_vec[sel];
          case (sel)
            2'd0:    begin shreg_d = {CFG_DATA, 32'h0};   len_d = 6'd8;  end
            2'd1:    begin shreg_d = {MOUSE_DATA, 16'h0}; len_d = 6'd24; end
            2'd2:    begin shreg_d = {KMP_DATA, 32'h0};   len_d = 6'd8;  end
            default: begin shreg_d = ~KBD_DATA;           len_d = 6'd40; end
          endcase
        end
      end
      StSetup: begin
        if (hold_done) begin
          state_d = StSelect;
          cnt_d   = HalfLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSelect: begin
        if (hold_done) begin
          state_d = StHigh;
          cnt_d   = HalfLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHigh: begin
        if (hold_done) begin
          state_d = StLow;
          cnt_d   = HalfLd;
          bit_d   = bit_q + 6'd1;
          // Zero fill means MOSI is 0 in the low half after the last bit.
          shreg_d = {shreg_q[38:0], 1'b0};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StLow: begin
        if (hold_done) begin
          state_d = (bit_q == len_q) ? StTail : StHigh;
          cnt_d   = HalfLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StTail: begin
        if (hold_done) begin
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Pin values are derived from the next state and registered, so the pins
  // track state_q with no combinational path from the inputs.
  always_comb begin
    sck_d     = (state_d == StHigh);
    nss_d     = !(state_d inside {StSelect, StHigh, StLow, StTail});
    mosi_d    = (state_d inside {StSelect, StHigh, StLow}) ? shreg_d[39] : 1'b0;
    a_d       = (state_q == StIdle && state_d == StSetup) ? ch_d : SPI_A;
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StRelease);
    done_ch_d = (state_d == StRelease) ? ch_d : DONE_CH;
  end

  always_ff @(posedge CLK14M or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      len_q    <= '0;
      ch_q     <= '0;
      shreg_q  <= '0;
      pend_q   <= '0;
      SPI_SCK  <= 1'b0;
      SPI_NSS  <= 1'b1;
      SPI_MOSI <= 1'b0;
      SPI_A    <= 2'b00;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      DONE_CH  <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      len_q    <= len_d;
      ch_q     <= ch_d;
      shreg_q  <= shreg_d;
      pend_q   <= pend_d;
      SPI_SCK  <= sck_d;
      SPI_NSS  <= nss_d;
      SPI_MOSI <= mosi_d;
      SPI_A    <= a_d;
      BUSY     <= busy_d;
      DONE     <= done_d;
      DONE_CH  <= done_ch_d;
    end
  end

endmodule

// File: tb/tb_zx_spi_feeder.sv
// Self-checking bench for zx_spi_feeder: a receiver model captures MOSI on
// each SCK rise and compares finished frames against a queue of expected
// register contents.
module tb_zx_spi_feeder;

  logic        CLK14M = 1'b0;
  logic        RESET;
  logic        CFG_REQ = 1'b0, MOUSE_REQ = 1'b0, KMP_REQ = 1'b0, KBD_REQ = 1'b0;
  logic [7:0]  CFG_DATA = '0;
  logic [23:0] MOUSE_DATA = '0;
  logic [7:0]  KMP_DATA = '0;
  logic [39:0] KBD_DATA = '0;
  logic        SPI_SCK, SPI_NSS, SPI_MOSI, BUSY, DONE;
  logic [1:0]  SPI_A, DONE_CH;

  zx_spi_feeder #(.HALF_DIV(4), .GAP(2)) dut (
    .CLK14M    (CLK14M),
    .RESET     (RESET),
    .CFG_REQ   (CFG_REQ),
    .MOUSE_REQ (MOUSE_REQ),
    .KMP_REQ   (KMP_REQ),
    .KBD_REQ   (KBD_REQ),
    .CFG_DATA  (CFG_DATA),
    .MOUSE_DATA(MOUSE_DATA),
    .KMP_DATA  (KMP_DATA),
    .KBD_DATA  (KBD_DATA),
    .SPI_SCK   (SPI_SCK),
    .SPI_NSS   (SPI_NSS),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_A     (SPI_A),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .DONE_CH   (DONE_CH)
  );

  always #5 CLK14M = ~CLK14M;

  typedef struct {
    logic [1:0]  ch;
    int          n;
    logic [39:0] val;
  } exp_t;

  typedef struct {
    logic [1:0]  ch;
    logic [39:0] data;
    int          n;
    int          lat;   // request edge to DONE: GAP + HALF_DIV*(2N+2) + 1
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   done_seen = 0;
  int   rises = 0;
  logic [39:0] rx = '0;
  logic [1:0]  frame_a = '0;
  logic        prev_sck = 1'b0, prev_nss = 1'b1, prev_mosi = 1'b0;
  logic [1:0]  prev_a = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receiver model: shift-left on SCK rise, keyboard register stores ~MOSI.
  always @(negedge CLK14M) begin
    if (RESET) begin
      rx = '0;
      rises = 0;
    end else begin
      if (SPI_A !== prev_a) chk("a_change_only_nss_high", SPI_NSS, 1);
      if (prev_sck && SPI_SCK) chk("mosi_stable_while_sck_high", SPI_MOSI, prev_mosi);
      if (!SPI_NSS && prev_nss) begin
        frame_a = SPI_A;
        rx = '0;
        rises = 0;
      end
      if (SPI_SCK && !prev_sck) begin
        rises++;
        rx = {rx[38:0], (frame_a == 2'b11) ? ~SPI_MOSI : SPI_MOSI};
      end
      if (DONE) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_ch", DONE_CH, e.ch);
          chk("frame_addr", frame_a, e.ch);
          chk("sck_rises", rises, e.n);
          chk("rx_register", rx, e.val);
        end
        done_seen++;
      end
    end
    prev_sck  = SPI_SCK;
    prev_nss  = SPI_NSS;
    prev_mosi = SPI_MOSI;
    prev_a    = SPI_A;
  end

  task automatic set_data(input logic [1:0] ch, input logic [39:0] data);
    case (ch)
      2'd0:    CFG_DATA = data[7:0];
      2'd1:    MOUSE_DATA = data[23:0];
      2'd2:    KMP_DATA = data[7:0];
      default: KBD_DATA = data;
    endcase
  endtask

  // Returns at the negedge following the clock edge that sampled the request.
  task automatic pulse_req(input logic [1:0] ch);
    @(negedge CLK14M);
    case (ch)
      2'd0:    CFG_REQ = 1'b1;
      2'd1:    MOUSE_REQ = 1'b1;
      2'd2:    KMP_REQ = 1'b1;
      default: KBD_REQ = 1'b1;
    endcase
    @(negedge CLK14M);
    CFG_REQ = 1'b0; MOUSE_REQ = 1'b0; KMP_REQ = 1'b0; KBD_REQ = 1'b0;
  endtask

  task automatic wait_dones(input int n, input string name);
    int target;
    int cyc;
    target = done_seen + n;
    cyc = 0;
    while (done_seen < target && cyc < 3000) begin
      @(negedge CLK14M);
      cyc++;
    end
    chk(name, done_seen, target);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK14M);
  endtask

  vec_t vecs[5];

  initial begin
    int lat;
    int base;
    int nss_low;

    vecs[0] = '{2'd0, 40'h00_0000_00A5, 8, 75};
    vecs[1] = '{2'd3, 40'h00_0000_0001, 40, 331};
    vecs[2] = '{2'd1, 40'h00_0012_3456, 24, 203};
    vecs[3] = '{2'd2, 40'h00_0000_001F, 8, 75};
    vecs[4] = '{2'd3, 40'hF0_0FA5_5AC3, 40, 331};

    RESET = 1'b1;
    wait_cycles(3);
    chk("rst_sck", SPI_SCK, 0);
    chk("rst_nss", SPI_NSS, 1);
    chk("rst_mosi", SPI_MOSI, 0);
    chk("rst_a", SPI_A, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_done_ch", DONE_CH, 0);
    RESET = 1'b0;
    wait_cycles(3);

    // Single frames: latency, address at SETUP entry, BUSY framing.
    for (int i = 0; i < 5; i++) begin
      set_data(vecs[i].ch, vecs[i].data);
      sb.push_back('{vecs[i].ch, vecs[i].n, vecs[i].data});
      pulse_req(vecs[i].ch);
      lat = 0;
      while (!DONE && lat < 2000) begin
        @(negedge CLK14M);
        lat++;
        if (lat == 1) begin
          chk("setup_busy", BUSY, 1);
          chk("setup_nss", SPI_NSS, 1);
          chk("setup_a", SPI_A, vecs[i].ch);
        end
      end
      chk("done_latency", lat, vecs[i].lat);
      @(negedge CLK14M);
      chk("busy_after_done", BUSY, 0);
      chk("done_one_cycle", DONE, 0);
      wait_cycles(5);
    end

    // Mouse and kempston in the same cycle: mouse wins, kempston follows.
    MOUSE_DATA = 24'h123456;
    KMP_DATA   = 8'h1F;
    sb.push_back('{2'd1, 24, 40'h12_3456});
    sb.push_back('{2'd2, 8, 40'h1F});
    @(negedge CLK14M);
    MOUSE_REQ = 1'b1; KMP_REQ = 1'b1;
    @(negedge CLK14M);
    MOUSE_REQ = 1'b0; KMP_REQ = 1'b0;
    wait_dones(2, "mouse_kmp_dones");
    wait_cycles(5);

    // Cfg request during a kbd frame; kbd data changes mid-frame.
    KBD_DATA = 40'h5A_C3F0_0F11;
    sb.push_back('{2'd3, 40, 40'h5A_C3F0_0F11});
    pulse_req(2'd3);
    wait_cycles(60);
    CFG_DATA = 8'h3C;
    sb.push_back('{2'd0, 8, 40'h3C});
    pulse_req(2'd0);
    KBD_DATA = 40'hFF_FFFF_FFFF;
    wait_dones(2, "kbd_then_cfg_dones");
    wait_cycles(5);

    // Three kempston requests while busy collapse into one extra frame.
    KMP_DATA = 8'h81;
    sb.push_back('{2'd2, 8, 40'h81});
    pulse_req(2'd2);
    wait_cycles(15);
    chk("kmp_busy", BUSY, 1);
    sb.push_back('{2'd2, 8, 40'h81});
    for (int k = 0; k < 3; k++) begin
      pulse_req(2'd2);
      wait_cycles(4);
    end
    wait_dones(2, "kmp_collapse_dones");
    base = done_seen;
    wait_cycles(300);
    chk("kmp_no_third_frame", done_seen, base);

    // Reset after 10 rises of a kbd frame with a mouse request pending.
    KBD_DATA = 40'h12_3456_789A;
    sb.push_back('{2'd3, 40, 40'h12_3456_789A});
    pulse_req(2'd3);
    wait_cycles(10);
    pulse_req(2'd1);
    lat = 0;
    while (rises < 10 && lat < 2000) begin
      @(negedge CLK14M);
      lat++;
    end
    chk("reached_10_rises", rises, 10);
    base = done_seen;
    #2;
    RESET = 1'b1;
    #1;
    chk("abort_nss", SPI_NSS, 1);
    chk("abort_sck", SPI_SCK, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    sb.delete();
    wait_cycles(3);
    RESET = 1'b0;
    nss_low = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK14M);
      if (!SPI_NSS || BUSY) nss_low++;
    end
    chk("no_frame_after_reset", nss_low, 0);
    chk("no_done_after_reset", done_seen, base);
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
